runway_scheduler: RTL and testbench

//  Shares NUM_RUNWAYS runways between the takeoff queue (FIFO head) and landing requesters.

---
 rtl/runway_scheduler_pkg.sv | 21 ++
 rtl/runway_slot.sv | 42 ++++
 rtl/runway_scheduler.sv | 134 +++++++++++++
 tb/tb_runway_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/runway_scheduler_pkg.sv
// Shared types for the runway scheduler: per-runway state, scheduler FSM state
// and a wrap helper for the round-robin search.
package runway_scheduler_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        RSV_TO = 2'd1,
        RSV_LD = 2'd2
    } runway_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    // Wrap an index that is at most 2*n-1 back into [0, n).
    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? i - n : i;
    endfunction

endpackage

// File: rtl/runway_slot.sv
// One runway: reservation state plus a saturating timer that flags a
// reservation left unreleased for TIMEOUT cycles.
module runway_slot
    import runway_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          reserve_to,
    input  logic          reserve_ld,
    input  logic          release_hit,
    output runway_state_t state,
    output logic          timeout_flag
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Reservations only land on a FREE runway, so a release to a FREE runway
    // (an error handled by the parent) never disturbs a same-cycle reservation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FREE;
            count <= '0;
        end else if (state == FREE) begin
            if (reserve_ld)
                state <= RSV_LD;
            else if (reserve_to)
                state <= RSV_TO;
        end else if (release_hit) begin
            state <= FREE;
            count <= '0;
        end else if (count != CW'(TIMEOUT)) begin
            count <= count + 1'b1;
        end
    end

    assign timeout_flag = (count == CW'(TIMEOUT));

endmodule

// File: rtl/runway_scheduler.sv
// Grants runways to landing requests (first) and the takeoff queue head,
// round-robin over eligible runways, with an emergency lock on new grants.
module runway_scheduler
    import runway_scheduler_pkg::*;
#(
    parameter  int NUM_RUNWAYS = 2,
    parameter  int ID_W        = 4,
    parameter  int TIMEOUT     = 1024,
    localparam int RW          = (NUM_RUNWAYS > 1) ? $clog2(NUM_RUNWAYS) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   tq_empty,
    input  logic [ID_W-1:0]        tq_id,
    output logic                   tq_pop,
    input  logic                   ld_req,
    input  logic [ID_W-1:0]        ld_id,
    output logic                   ld_ack,
    input  logic                   release_valid,
    input  logic [RW-1:0]          release_runway,
    output logic                   release_err,
    input  logic                   emergency,
    input  logic                   emergency_clear,
    input  logic [NUM_RUNWAYS-1:0] runway_landing,
    output logic                   grant_valid,
    input  logic                   grant_ready,
    output logic [ID_W-1:0]        grant_id,
    output logic [RW-1:0]          grant_runway,
    output logic                   grant_landing,
    output logic [NUM_RUNWAYS-1:0] runway_takeoff,
    output logic [NUM_RUNWAYS-1:0] runway_ld_rsv,
    output logic [NUM_RUNWAYS-1:0] timeout_flag,
    output logic                   emergency_active
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [RW-1:0]   runway;
        logic            landing;
    } grant_t;

    sched_state_t  state, state_nx;
    grant_t        grant_q;
    logic [RW-1:0] rr_ptr, sel_idx;
    logic          sel_found, do_grant, emer_lock, release_err_q;
    int            idx;

    runway_state_t          rs [NUM_RUNWAYS];
    logic [NUM_RUNWAYS-1:0] eligible, free_v, rsv_to_v, rsv_ld_v;
    logic [NUM_RUNWAYS-1:0] rel_hit, res_to, res_ld;

    for (genvar i = 0; i < NUM_RUNWAYS; i++) begin : g_slot
        assign rel_hit[i] = release_valid && (release_runway == RW'(i));
        assign res_ld[i]  = do_grant && ld_req && (sel_idx == RW'(i));
        assign res_to[i]  = do_grant && !ld_req && (sel_idx == RW'(i));

        runway_slot #(.TIMEOUT(TIMEOUT)) u_slot (
            .clock        (clock),
            .reset_n      (reset_n),
            .reserve_to   (res_to[i]),
            .reserve_ld   (res_ld[i]),
            .release_hit  (rel_hit[i]),
            .state        (rs[i]),
            .timeout_flag (timeout_flag[i])
        );

        assign free_v[i]   = (rs[i] == FREE);
        assign rsv_to_v[i] = (rs[i] == RSV_TO);
        assign rsv_ld_v[i] = (rs[i] == RSV_LD);
        assign eligible[i] = free_v[i] && !runway_landing[i];
    end

    // First eligible runway at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_RUNWAYS; k++) begin
            idx = wrap_idx(int'(rr_ptr) + k, NUM_RUNWAYS);
            if (!sel_found && eligible[idx[RW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx[RW-1:0];
            end
        end
    end

    // reset_n gates the handshakes so every output reads 0 while reset is held.
    assign do_grant = reset_n && (state == IDLE) && !emer_lock && sel_found &&
                      (ld_req || !tq_empty);
    assign ld_ack   = do_grant && ld_req;
    assign tq_pop   = do_grant && !ld_req;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (do_grant) state_nx = ISSUE;
            ISSUE:   if (grant_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_q       <= '0;
            emer_lock     <= 1'b0;
            release_err_q <= 1'b0;
        end else begin
            state         <= state_nx;
            release_err_q <= |(rel_hit & free_v);
            if (emergency)
                emer_lock <= 1'b1;
            else if (emergency_clear)
                emer_lock <= 1'b0;
            if (do_grant) begin
                grant_q.id      <= ld_req ? ld_id : tq_id;
                grant_q.runway  <= sel_idx;
                grant_q.landing <= ld_req;
                rr_ptr          <= RW'(wrap_idx(int'(sel_idx) + 1, NUM_RUNWAYS));
            end
        end
    end

    assign grant_valid      = (state == ISSUE);
    assign grant_id         = grant_q.id;
    assign grant_runway     = grant_q.runway;
    assign grant_landing    = grant_q.landing;
    assign release_err      = release_err_q;
    assign emergency_active = emer_lock;
    assign runway_takeoff   = emer_lock ? '1 : rsv_to_v;
    assign runway_ld_rsv    = emer_lock ? '1 : rsv_ld_v;

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed bench for runway_scheduler: expected grants go into a scoreboard
// queue and a negedge monitor compares them on every accepted grant.
module tb_runway_scheduler;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tq_empty, tq_pop, ld_req, ld_ack;
    logic [3:0] tq_id, ld_id, grant_id;
    logic       release_valid, release_runway, release_err;
    logic       emergency, emergency_clear, emergency_active;
    logic [1:0] runway_landing, runway_takeoff, runway_ld_rsv, timeout_flag;
    logic       grant_valid, grant_ready, grant_runway, grant_landing;

    typedef struct {
        logic [3:0] id;
        logic       rw;
        logic       ld;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    runway_scheduler #(.NUM_RUNWAYS(2), .ID_W(4), .TIMEOUT(8)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .tq_empty         (tq_empty),
        .tq_id            (tq_id),
        .tq_pop           (tq_pop),
        .ld_req           (ld_req),
        .ld_id            (ld_id),
        .ld_ack           (ld_ack),
        .release_valid    (release_valid),
        .release_runway   (release_runway),
        .release_err      (release_err),
        .emergency        (emergency),
        .emergency_clear  (emergency_clear),
        .runway_landing   (runway_landing),
        .grant_valid      (grant_valid),
        .grant_ready      (grant_ready),
        .grant_id         (grant_id),
        .grant_runway     (grant_runway),
        .grant_landing    (grant_landing),
        .runway_takeoff   (runway_takeoff),
        .runway_ld_rsv    (runway_ld_rsv),
        .timeout_flag     (timeout_flag),
        .emergency_active (emergency_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        tq_empty = 1'b1; tq_id = '0; ld_req = 1'b0; ld_id = '0;
        release_valid = 1'b0; release_runway = 1'b0;
        emergency = 1'b0; emergency_clear = 1'b0;
        runway_landing = '0; grant_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tq_pop"}, tq_pop, 0);
        chk({tag, "_ld_ack"}, ld_ack, 0);
        chk({tag, "_release_err"}, release_err, 0);
        chk({tag, "_grant_valid"}, grant_valid, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_grant_runway"}, grant_runway, 0);
        chk({tag, "_grant_landing"}, grant_landing, 0);
        chk({tag, "_runway_takeoff"}, runway_takeoff, 0);
        chk({tag, "_runway_ld_rsv"}, runway_ld_rsv, 0);
        chk({tag, "_timeout_flag"}, timeout_flag, 0);
        chk({tag, "_emergency_active"}, emergency_active, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        sb.delete();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Scoreboard monitor: compare every accepted grant against the queue head.
    always @(negedge clock) begin
        if (reset_n && grant_valid && grant_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got id %0d runway %0d landing %0d, none expected",
                         grant_id, grant_runway, grant_landing);
            end else begin
                e = sb.pop_front();
                chk("grant_id", grant_id, e.id);
                chk("grant_runway", grant_runway, e.rw);
                chk("grant_landing", grant_landing, e.ld);
            end
        end
        if (tq_pop)
            chk("pop_while_empty", tq_empty, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        #2;
        chk_all_zero("reset");
        step();
        reset_n = 1'b1;
        step();

        // 1: single takeoff
        tq_empty = 1'b0; tq_id = 4'd5;
        sb.push_back('{4'd5, 1'b0, 1'b0});
        #1 chk("t1_pop", tq_pop, 1);
        step();
        tq_empty = 1'b1;
        #1 chk("t1_pop_once", tq_pop, 0);
        chk("t1_gv", grant_valid, 1);
        chk("t1_rto", runway_takeoff, 2'b01);
        grant_ready = 1'b1;
        step();
        grant_ready = 1'b0;
        #1 chk("t1_back_idle", grant_valid, 0);

        // 2: landing beats takeoff, then takeoff on the next runway
        do_reset();
        ld_req = 1'b1; ld_id = 4'd3; tq_empty = 1'b0; tq_id = 4'd7; grant_ready = 1'b1;
        sb.push_back('{4'd3, 1'b0, 1'b1});
        sb.push_back('{4'd7, 1'b1, 1'b0});
        #1 chk("t2_ld_ack", ld_ack, 1);
        chk("t2_no_pop", tq_pop, 0);
        step();
        ld_req = 1'b0;
        #1 chk("t2_issue_no_pop", tq_pop, 0);
        step();
        #1 chk("t2_pop", tq_pop, 1);
        step();
        tq_empty = 1'b1;
        step();
        grant_ready = 1'b0;
        #1 chk("t2_rto", runway_takeoff, 2'b10);
        chk("t2_rld", runway_ld_rsv, 2'b01);

        // 3: both busy; release runway 1 frees it for the waiting takeoff
        tq_empty = 1'b0; tq_id = 4'd9;
        #1 chk("t3_wait", tq_pop, 0);
        step();
        release_valid = 1'b1; release_runway = 1'b1;
        sb.push_back('{4'd9, 1'b1, 1'b0});
        #1 chk("t3_pre_release", tq_pop, 0);
        step();
        release_valid = 1'b0;
        #1 chk("t3_rto_free", runway_takeoff, 2'b00);
        chk("t3_rld", runway_ld_rsv, 2'b01);
        chk("t3_pop", tq_pop, 1);
        chk("t3_no_err", release_err, 0);
        step();
        tq_empty = 1'b1; grant_ready = 1'b1;
        #1 chk("t3_gv", grant_valid, 1);
        step();
        grant_ready = 1'b0;

        // 4: emergency lockout and clear
        do_reset();
        emergency = 1'b1;
        step();
        emergency = 1'b0; tq_empty = 1'b0; tq_id = 4'd4;
        #1 chk("t4_active", emergency_active, 1);
        chk("t4_rto_ones", runway_takeoff, 2'b11);
        chk("t4_rld_ones", runway_ld_rsv, 2'b11);
        chk("t4_no_pop", tq_pop, 0);
        step();
        #1 chk("t4_no_grant", grant_valid, 0);
        emergency_clear = 1'b1;
        sb.push_back('{4'd4, 1'b0, 1'b0});
        #1 chk("t4_still_locked", tq_pop, 0);
        step();
        emergency_clear = 1'b0;
        #1 chk("t4_cleared", emergency_active, 0);
        chk("t4_pop", tq_pop, 1);
        step();
        tq_empty = 1'b1; grant_ready = 1'b1;
        #1 chk("t4_gv", grant_valid, 1);
        step();
        grant_ready = 1'b0;
        emergency = 1'b1; emergency_clear = 1'b1;
        step();
        emergency = 1'b0; emergency_clear = 1'b0;
        #1 chk("t4_set_wins", emergency_active, 1);
        emergency_clear = 1'b1;
        step();
        emergency_clear = 1'b0;
        #1 chk("t4_clear_again", emergency_active, 0);

        // 5: timeout after 8 reserved cycles, held, cleared by release
        do_reset();
        tq_empty = 1'b0; tq_id = 4'd6;
        sb.push_back('{4'd6, 1'b0, 1'b0});
        #1 chk("t5_pop", tq_pop, 1);
        step();
        tq_empty = 1'b1; grant_ready = 1'b1;
        #1 chk("t5_rto", runway_takeoff, 2'b01);
        chk("t5_flag_lo_first", timeout_flag, 0);
        step();
        grant_ready = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            #1 chk("t5_flag_lo", timeout_flag, 0);
            step();
        end
        #1 chk("t5_flag_hi", timeout_flag, 2'b01);
        step(); step(); step();
        #1 chk("t5_flag_held", timeout_flag, 2'b01);
        chk("t5_still_rsv", runway_takeoff, 2'b01);
        release_valid = 1'b1; release_runway = 1'b0;
        step();
        release_valid = 1'b0;
        #1 chk("t5_flag_clr", timeout_flag, 0);
        chk("t5_freed", runway_takeoff, 0);
        chk("t5_no_err", release_err, 0);
        release_valid = 1'b1;
        step();
        release_valid = 1'b0;
        #1 chk("t5_err", release_err, 1);
        step();
        #1 chk("t5_err_pulse", release_err, 0);

        // 6: external landing occupancy skips runway 0; reset mid-ISSUE
        do_reset();
        runway_landing = 2'b01; tq_empty = 1'b0; tq_id = 4'd2;
        #1 chk("t6_pop", tq_pop, 1);
        step();
        tq_empty = 1'b1;
        #1 chk("t6_gv", grant_valid, 1);
        chk("t6_grant_id", grant_id, 2);
        chk("t6_grant_rw", grant_runway, 1);
        chk("t6_rto", runway_takeoff, 2'b10);
        tq_empty = 1'b0;
        reset_n = 1'b0;
        #1 chk_all_zero("t6_reset");
        step();
        idle_inputs();
        reset_n = 1'b1;
        step();

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
